// File: rtl/coso_pkg.sv
// Shared types and default parameters for the coherent-sampler bit harvester.
package coso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DISCARD = 2'd1,
    ST_COLLECT = 2'd2,
    ST_FAIL    = 2'd3
  } coso_state_e;

  localparam int unsigned CS_CNT_LENGTH_DEF = 16;
  localparam int unsigned WORD_WIDTH_DEF    = 32;
  localparam int unsigned NB_DISCARD_DEF    = 4;
  localparam int unsigned RCT_CUTOFF_DEF    = 8;

endpackage

// File: rtl/coso_rct.sv
// Repetition-count health test: tracks the run length of identical raw bits
// and flags a failure when the run reaches the cutoff.
module coso_rct
  import coso_pkg::*;
#(
  parameter int unsigned RCTCutoff = RCT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic bit_i,
  input  logic valid_i,
  input  logic clear_i,
  output logic fail_o
);

  localparam logic [7:0] CUT = 8'(RCTCutoff);

  logic [7:0] run_q, run_d;
  logic       last_q, last_d;

  // Next run length: restart on a new value (or first bit), count repeats, saturate.
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (clear_i) begin
      run_d  = 8'd0;
      last_d = 1'b0;
    end else if (valid_i) begin
      last_d = bit_i;
      if (run_q == 8'd0 || bit_i != last_q) run_d = 8'd1;
      else if (run_q < CUT)                 run_d = run_q + 8'd1;
    end
  end

  // Failure is reported combinationally so the caller can act on the triggering bit.
  assign fail_o = valid_i && (run_d == CUT);

  // Run-length state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q  <= 8'd0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/coso_bit_harvester.sv
// Harvests raw bits (LSB of the sampler count) into words once the matching
// controller reports a usable lock, with discard warm-up, a repetition-count
// health test and a single-entry output buffer with sticky overflow.
module coso_bit_harvester
  import coso_pkg::*;
#(
  parameter int unsigned CSCntLength = CS_CNT_LENGTH_DEF,
  parameter int unsigned WordWidth   = WORD_WIDTH_DEF,
  parameter int unsigned NBDiscard   = NB_DISCARD_DEF,
  parameter int unsigned RCTCutoff   = RCT_CUTOFF_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [CSCntLength-1:0] CSCnt,
  input  logic                   CSReq,
  output logic                   CSAck,
  input  logic                   matched,
  input  logic                   locked,
  output logic [WordWidth-1:0]   dataOut,
  output logic                   dataValid,
  input  logic                   dataReady,
  input  logic                   clrFail,
  output logic                   healthFail,
  output logic                   overflow
);

  localparam int unsigned BW = (WordWidth > 1) ? $clog2(WordWidth) : 1;
  localparam int unsigned DW = (NBDiscard > 1) ? $clog2(NBDiscard) : 1;
  localparam logic [BW-1:0] BLAST = BW'(WordWidth - 1);
  localparam logic [DW-1:0] DLAST = DW'((NBDiscard == 0) ? 0 : NBDiscard - 1);

  coso_state_e          state_q, state_d;
  logic                 ack_q, ack_d;
  logic [WordWidth-1:0] shift_q, shift_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic [WordWidth-1:0] dout_q, dout_d;
  logic                 dvld_q, dvld_d;
  logic                 hfail_q, hfail_d;
  logic                 ovf_q, ovf_d;

  logic accept, raw, link_ok, pop, rct_valid, rct_clear, rct_fail;
  logic [WordWidth-1:0] word_next;
  logic unused_cscnt;

  assign accept    = CSReq & ~ack_q;
  assign raw       = CSCnt[0];
  assign link_ok   = matched & ~locked;
  assign pop       = dvld_q & dataReady;
  assign word_next = {shift_q[WordWidth-2:0], raw};
  assign rct_valid = accept & link_ok & (state_q == ST_COLLECT);
  // Run length restarts on clrFail and whenever the link is lost mid-collection.
  assign rct_clear = ((state_q == ST_FAIL) & clrFail) |
                     (((state_q == ST_DISCARD) | (state_q == ST_COLLECT)) & ~link_ok);
  assign unused_cscnt = ^CSCnt[CSCntLength-1:1];

  coso_rct #(.RCTCutoff(RCTCutoff)) u_rct (
    .clk     (clk),
    .rstn    (rstn),
    .bit_i   (raw),
    .valid_i (rct_valid),
    .clear_i (rct_clear),
    .fail_o  (rct_fail)
  );

  // Next-state, handshake, shift register and output buffer.
  always_comb begin
    state_d = state_q;
    ack_d   = accept;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    dout_d  = dout_q;
    dvld_d  = dvld_q & ~pop;
    hfail_d = hfail_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (link_ok) begin
          dcnt_d  = '0;
          state_d = (NBDiscard == 0) ? ST_COLLECT : ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (!link_ok) begin
          state_d = ST_IDLE;
          shift_d = '0;
          bcnt_d  = '0;
          dcnt_d  = '0;
        end else if (accept) begin
          if (dcnt_q == DLAST) begin
            dcnt_d  = '0;
            state_d = ST_COLLECT;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
      ST_COLLECT: begin
        if (!link_ok) begin
          state_d = ST_IDLE;
          shift_d = '0;
          bcnt_d  = '0;
        end else if (accept) begin
          if (rct_fail) begin
            // The triggering bit never reaches the word.
            state_d = ST_FAIL;
            hfail_d = 1'b1;
            shift_d = '0;
            bcnt_d  = '0;
          end else begin
            shift_d = word_next;
            if (bcnt_q == BLAST) begin
              bcnt_d = '0;
              if (!dvld_q || pop) begin
                dout_d = word_next;
                dvld_d = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end
        end
      end
      ST_FAIL: begin
        if (clrFail) begin
          state_d = ST_IDLE;
          hfail_d = 1'b0;
          shift_d = '0;
          bcnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      shift_q <= '0;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      hfail_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      hfail_q <= hfail_d;
      ovf_q   <= ovf_d;
    end
  end

  assign CSAck      = ack_q;
  assign dataOut    = dout_q;
  assign dataValid  = dvld_q;
  assign healthFail = hfail_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_coso_bit_harvester.sv
// Bench for coso_bit_harvester: directed scenarios plus a randomized run,
// checked against a transaction-level reference model built on queues.
module tb_coso_bit_harvester;

  localparam int W   = 32;
  localparam int NBD = 4;
  localparam int CUT = 8;
  localparam int MI = 0, MD = 1, MC = 2, MF = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [15:0]   CSCnt;
  logic          CSReq, CSAck, matched, locked;
  logic [W-1:0]  dataOut;
  logic          dataValid, dataReady, clrFail, healthFail, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int           m_mode, m_disc, m_run;
  bit           m_last, m_ack, m_full, m_hf, m_ovf;
  bit           m_bits[$];
  logic [W-1:0] m_buf;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  always #5 clk = ~clk;

  coso_bit_harvester dut (
    .clk(clk), .rstn(rstn), .CSCnt(CSCnt), .CSReq(CSReq), .CSAck(CSAck),
    .matched(matched), .locked(locked), .dataOut(dataOut), .dataValid(dataValid),
    .dataReady(dataReady), .clrFail(clrFail), .healthFail(healthFail), .overflow(overflow)
  );

  // record every word that leaves through a completed handshake
  always @(negedge clk)
    if (rstn && dataValid && dataReady) got_q.push_back(dataOut);

  task automatic model_reset();
    m_mode = MI; m_disc = 0; m_run = 0; m_last = 0; m_ack = 0;
    m_full = 0; m_hf = 0; m_ovf = 0; m_buf = '0;
    m_bits.delete(); exp_q.delete(); got_q.delete();
  endtask

  // advance model by one clock using the inputs as they stand, then clock the DUT
  task automatic tick();
    bit acc, ok, pop, b;
    logic [W-1:0] word;
    acc = CSReq && !m_ack;
    ok  = matched && !locked;
    pop = m_full && dataReady;
    b   = CSCnt[0];
    m_ack = acc;
    if (pop) m_full = 0;
    if ((m_mode == MD || m_mode == MC) && !ok) begin
      m_mode = MI; m_bits.delete(); m_run = 0;
    end else if (m_mode == MI) begin
      if (ok) begin m_mode = (NBD == 0) ? MC : MD; m_disc = NBD; end
    end else if (m_mode == MF) begin
      if (clrFail) begin m_mode = MI; m_hf = 0; m_run = 0; m_bits.delete(); end
    end else if (acc) begin
      if (m_mode == MD) begin
        m_disc--;
        if (m_disc == 0) m_mode = MC;
      end else begin
        m_run  = (m_run > 0 && b == m_last) ? ((m_run < CUT) ? m_run + 1 : CUT) : 1;
        m_last = b;
        if (m_run == CUT) begin
          m_hf = 1; m_mode = MF; m_bits.delete();
        end else begin
          m_bits.push_back(b);
          if (m_bits.size() == W) begin
            word = '0;
            foreach (m_bits[i]) word = {word[W-2:0], m_bits[i]};
            if (!m_full) begin m_full = 1; m_buf = word; exp_q.push_back(word); end
            else m_ovf = 1;
            m_bits.delete();
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // one full request/acknowledge handshake carrying raw bit b
  task automatic send(input bit b);
    CSCnt = 16'($urandom);
    CSCnt[0] = b;
    CSReq = 1'b1;
    tick();
    CSReq = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0; CSReq = 0; CSCnt = '0; matched = 0; locked = 0;
    clrFail = 0; dataReady = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (CSAck !== 1'b0)    begin n_fail++; $display("FAIL reset_ack: got %b exp 0", CSAck); end
    n_tests++; if (dataValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", dataValid); end
    n_tests++; if (dataOut !== '0)     begin n_fail++; $display("FAIL reset_data: got %h exp 0", dataOut); end
    n_tests++; if (healthFail !== 1'b0) begin n_fail++; $display("FAIL reset_hf: got %b exp 0", healthFail); end
    n_tests++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", overflow); end
  endtask

  task automatic test_ack_toggle();
    int acks = 0;
    do_reset();
    CSReq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (CSAck === 1'b1) acks++;
      n_tests++;
      if (CSAck !== ((i % 2) == 0)) begin n_fail++; $display("FAIL ack_seq[%0d]: got %b exp %b", i, CSAck, (i % 2) == 0); end
    end
    CSReq = 1'b0;
    tick();
    n_tests++; if (acks != 5) begin n_fail++; $display("FAIL ack_count: got %0d exp 5", acks); end
    n_tests++; if (dataValid !== 1'b0) begin n_fail++; $display("FAIL ack_idle_valid: got %b exp 0", dataValid); end
  endtask

  task automatic test_basic();
    do_reset();
    // link comes up together with the first request, so that sample lands in IDLE
    matched = 1'b1;
    for (int k = 0; k < 36; k++) send((k % 2) == 0);
    CSCnt = 16'($urandom); CSCnt[0] = 1'b1; CSReq = 1'b1;
    tick();
    n_tests++; if (dataValid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b exp 1", dataValid); end
    n_tests++; if (dataOut !== 32'h55555555) begin n_fail++; $display("FAIL basic_word: got %h exp 55555555", dataOut); end
    n_tests++; if (dataOut !== m_buf) begin n_fail++; $display("FAIL basic_model: got %h exp %h", dataOut, m_buf); end
    CSReq = 1'b0;
    repeat (4) tick();
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL basic_pulses: got %0d exp 1", got_q.size()); end
    n_tests++; if (healthFail !== 1'b0) begin n_fail++; $display("FAIL basic_hf: got %b exp 0", healthFail); end
    n_tests++; if (got_q != exp_q) begin n_fail++; $display("FAIL basic_stream: got %0d words exp %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_rct();
    do_reset();
    matched = 1'b1;
    tick();
    for (int k = 0; k < NBD; k++) send($urandom_range(1));
    send(1'b0);
    for (int k = 0; k < 7; k++) send(1'b1);
    n_tests++; if (healthFail !== 1'b0) begin n_fail++; $display("FAIL rct_early: got %b exp 0", healthFail); end
    // eighth repeat arrives with clrFail asserted: the failure must still be taken
    CSCnt = 16'($urandom); CSCnt[0] = 1'b1; CSReq = 1'b1; clrFail = 1'b1;
    tick();
    CSReq = 1'b0; clrFail = 1'b0;
    n_tests++; if (healthFail !== 1'b1) begin n_fail++; $display("FAIL rct_trip: got %b exp 1", healthFail); end
    n_tests++; if (CSAck !== 1'b1) begin n_fail++; $display("FAIL rct_ack: got %b exp 1", CSAck); end
    tick();
    for (int k = 0; k < 40; k++) send(k[0]);
    n_tests++; if (dataValid !== 1'b0) begin n_fail++; $display("FAIL rct_fail_word: got %b exp 0", dataValid); end
    n_tests++; if (healthFail !== 1'b1) begin n_fail++; $display("FAIL rct_hold: got %b exp 1", healthFail); end
    matched = 1'b0;
    clrFail = 1'b1; tick(); clrFail = 1'b0;
    n_tests++; if (healthFail !== 1'b0) begin n_fail++; $display("FAIL rct_clear: got %b exp 0", healthFail); end
    matched = 1'b1;
    tick();
    for (int k = 0; k < NBD + W; k++) send(k[0]);
    repeat (3) tick();
    n_tests++; if (got_q.size() != 1 || got_q != exp_q) begin n_fail++; $display("FAIL rct_recover: got %0d words exp %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] first;
    bit start;
    do_reset();
    dataReady = 1'b0;
    matched = 1'b1;
    start = 1'($urandom);
    tick();
    for (int k = 0; k < NBD + W; k++) send(start ^ k[0]);
    first = dataOut;
    n_tests++; if (dataValid !== 1'b1 || dataOut !== m_buf) begin n_fail++; $display("FAIL ovf_first: got %b/%h exp 1/%h", dataValid, dataOut, m_buf); end
    for (int k = 0; k < W; k++) begin
      send(start ^ k[0]);
      n_tests++; if (dataOut !== first) begin n_fail++; $display("FAIL ovf_stable[%0d]: got %h exp %h", k, dataOut, first); end
    end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
    n_tests++; if (dataValid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b exp 1", dataValid); end
    dataReady = 1'b1;
    repeat (3) tick();
    n_tests++; if (got_q.size() != 1 || got_q[0] !== first) begin n_fail++; $display("FAIL ovf_drop: got %0d words exp 1", got_q.size()); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
  endtask

  task automatic test_abort();
    bit b;
    int run;
    do_reset();
    matched = 1'b1;
    tick();
    for (int k = 0; k < NBD + 10; k++) send(k[0]);
    matched = 1'b0;
    repeat (3) tick();
    n_tests++; if (dataValid !== 1'b0 || got_q.size() != 0) begin n_fail++; $display("FAIL abort_novalid: got %b/%0d exp 0/0", dataValid, got_q.size()); end
    matched = 1'b1;
    tick();
    b = 0; run = 0;
    for (int k = 0; k < NBD + W; k++) begin
      if ($urandom_range(1) == 1 || run >= CUT - 1) begin b = ~b; run = 1; end else run++;
      send(b);
    end
    repeat (3) tick();
    n_tests++; if (got_q.size() != 1 || got_q != exp_q) begin n_fail++; $display("FAIL abort_newword: got %0d words exp %0d", got_q.size(), exp_q.size()); end
    n_tests++; if (healthFail !== 1'b0) begin n_fail++; $display("FAIL abort_hf: got %b exp 0", healthFail); end
  endtask

  task automatic test_random();
    bit b = 0;
    do_reset();
    matched = 1'b1;
    tick();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(49) == 0) matched = ~matched;
      if ($urandom_range(79) == 0) locked = ~locked;
      dataReady = 1'($urandom);
      if ($urandom_range(3) == 0) b = ~b;
      send(b);
      n_tests++;
      if (healthFail !== m_hf || overflow !== m_ovf || dataValid !== m_full || (m_full && dataOut !== m_buf)) begin
        n_fail++;
        $display("FAIL rand[%0d]: got hf%b ov%b v%b d%h exp hf%b ov%b v%b d%h", k, healthFail, overflow, dataValid, dataOut, m_hf, m_ovf, m_full, m_buf);
      end
      if (healthFail && $urandom_range(2) == 0) begin clrFail = 1'b1; tick(); clrFail = 1'b0; end
    end
    dataReady = 1'b1;
    repeat (3) tick();
    n_tests++; if (got_q != exp_q) begin n_fail++; $display("FAIL rand_stream: got %0d words exp %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    dataReady = 1'b0;
    matched = 1'b1;
    tick();
    for (int k = 0; k < NBD + 2 * W + 5; k++) send(k[0]);
    n_tests++; if (dataValid !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got %b/%b exp 1/1", dataValid, overflow); end
    CSReq = 1'b1;
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    n_tests++;
    if (CSAck !== 0 || dataValid !== 0 || dataOut !== '0 || healthFail !== 0 || overflow !== 0) begin
      n_fail++;
      $display("FAIL areset_outputs: got ack%b v%b d%h hf%b ov%b exp all 0", CSAck, dataValid, dataOut, healthFail, overflow);
    end
    // request withdrawn while in reset: nothing may be acknowledged afterwards
    CSReq = 1'b0;
    #3 rstn = 1'b1;
    model_reset();
    repeat (2) begin
      tick();
      n_tests++; if (CSAck !== 1'b0) begin n_fail++; $display("FAIL areset_noack: got %b exp 0", CSAck); end
    end
    CSReq = 1'b1;
    tick();
    CSReq = 1'b0;
    n_tests++; if (CSAck !== 1'b1) begin n_fail++; $display("FAIL areset_newack: got %b exp 1", CSAck); end
    tick();
  endtask

  initial begin
    test_reset();
    test_ack_toggle();
    test_basic();
    test_rct();
    test_overflow();
    test_abort();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/coso_bit_harvester.md
COSO_BIT_HARVESTER -- requirements
Module: coso_bit_harvester

Interface
REQ-001 SHALL have parameter CSCntLength, default 16, coherent sampler counter width.
REQ-002 SHALL have parameter WordWidth, default 32, output word width in bits.
REQ-003 SHALL have parameter NBDiscard, default 4, samples discarded after each entry into collection.
REQ-004 SHALL have parameter RCTCutoff, default 8, repetition-count health-test cutoff (range 2..255).
REQ-005 SHALL have ports: clk input 1, system clock; rstn input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: CSCnt input CSCntLength, sampler count; CSReq input 1, count stable; CSAck output 1, count consumed.
REQ-007 SHALL have ports: matched input 1 and locked input 1, status from the matching controller.
REQ-008 SHALL have ports: dataOut output WordWidth, harvested word; dataValid output 1; dataReady input 1.
REQ-009 SHALL have ports: clrFail input 1, clears the health failure; healthFail output 1; overflow output 1, sticky word-drop flag.

Function
REQ-010 SHALL accept a sample when CSReq=1 and CSAck=0, and SHALL drive CSAck=1 in the next cycle for exactly one cycle, in every state.
REQ-011 SHALL use CSCnt[0] of an accepted sample as the raw bit.
REQ-012 SHALL implement states IDLE, DISCARD, COLLECT and FAIL.
REQ-013 IDLE->DISCARD when matched=1 and locked=0; accepted samples in IDLE SHALL be ignored.
REQ-014 DISCARD SHALL drop NBDiscard accepted samples, then go to COLLECT; NBDiscard=0 SHALL go directly to COLLECT.
REQ-015 COLLECT SHALL shift each raw bit into a WordWidth shift register at the LSB end, counting bits 0..WordWidth-1.
REQ-016 On the WordWidth-th bit: if the output buffer is empty or is being emptied in that cycle, SHALL load it; otherwise SHALL drop the word and set overflow; the bit count SHALL wrap to 0 in both cases.
REQ-017 The output buffer SHALL present dataValid=1 from the cycle after loading until a cycle with dataValid=1 and dataReady=1; dataOut SHALL stay stable while dataValid=1 and dataReady=0.
REQ-018 In DISCARD or COLLECT, matched=0 or locked=1 SHALL go to IDLE, clear the partial word and bit count, and keep a buffered word valid.
REQ-019 SHALL run the repetition-count test on every raw bit in COLLECT: run length resets to 1 on a bit change and increments on a repeat, saturating at RCTCutoff.
REQ-020 When run length reaches RCTCutoff, SHALL set healthFail, go to FAIL, and discard the partial word, including the triggering bit.
REQ-021 FAIL SHALL ignore samples except for acknowledging them; clrFail=1 SHALL clear healthFail, the run length and the partial word, then go to IDLE.
REQ-022 If clrFail=1 and a failure occur in the same cycle, the failure SHALL win.
REQ-023 overflow SHALL stay set until reset.
REQ-024 Output latency SHALL be one cycle from the accepting edge of the WordWidth-th bit to dataValid=1.

Reset
REQ-025 rstn=0 SHALL asynchronously force IDLE with CSAck=0, dataValid=0, dataOut=0, healthFail=0, overflow=0, and shift register, counters and run length at 0.
REQ-026 Reset deassertion in the middle of a handshake SHALL cause no acknowledgement until a new CSReq=1 is sampled.

Structure
REQ-027 Shared package coso_pkg SHALL hold the state encoding type and the default parameter constants.
REQ-028 The repetition-count test SHALL be a sub-module, coso_rct, with bit input, valid input, clear input and fail output.

Verification
REQ-029 matched=1, 4+32 samples with alternating CSCnt[0] starting at 1, dataReady=1 -> exactly one dataValid pulse with dataOut=32'h55555555, no healthFail.
REQ-030 CSReq held high for 10 cycles -> CSAck toggles 0,1,0,1,... with 5 acknowledgements and 5 samples accepted.
REQ-031 Eight consecutive 1 bits in COLLECT with RCTCutoff=8 -> healthFail=1 in the cycle after the 8th acceptance; after clrFail pulse -> IDLE with healthFail=0.
REQ-032 dataReady=0 while 64 alternating bits are collected -> first word held stable, second word dropped, overflow=1.
REQ-033 matched drops after 10 collected bits -> IDLE, no dataValid; matched rises again -> 4 discarded, then a full new word.
REQ-034 rstn pulsed low asynchronously mid-word with dataValid=1 -> all outputs 0 immediately, without waiting for a clock edge.
